// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings
//   - responder FSM state encoding
//   - access_ok(): funct3 / alignment legality for a load or store
package data_mem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Legal funct3 for the direction plus natural alignment.
   // Unsigned variants exist only for loads.
   function automatic logic access_ok(input logic       write,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~write;
         F3_HU:   ok = ~write & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// mem_lane_align: combinational byte-lane steering for the data memory.
//   funct3     : access size / signedness
//   byte_off   : addr[1:0]
//   store_data : raw store data (low byte / half used for SB / SH)
//   load_word  : full 32-bit word read from storage
//   byte_en    : per-byte write enables for the store
//   wdata_rep  : store data replicated onto every lane it could land on
//   load_data  : selected and sign/zero-extended load result
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Store path: replicate data so the enables alone pick the lane.
   always_comb begin
      byte_en   = 4'b1111;
      wdata_rep = store_data;
      case (funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << byte_off;
            wdata_rep = {4{store_data[7:0]}};
         end
         2'b01: begin
            byte_en   = 4'b0011 << {byte_off[1], 1'b0};
            wdata_rep = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Load path.
   assign lane_byte = load_word[{byte_off, 3'b000} +: 8];
   assign lane_half = byte_off[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      load_data = load_word;
      case (funct3)
         F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   load_data = {24'd0, lane_byte};
         F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
         F3_HU:   load_data = {16'd0, lane_half};
         default: load_data = load_word;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: stalling data-memory model for the core's load/store port.
// Accepts one request in IDLE, waits LATENCY cycles (legal requests only),
// performs the access and returns a single-cycle response.
//   clk, rst                         : clock, async active-high reset
//   req_valid / req_ready            : request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata,
//   req_funct3                       : request payload, sampled on accept
//   rsp_valid                        : one-cycle response pulse
//   rsp_rdata                        : load result, 0 otherwise
//   rsp_err                          : request rejected (no side effect)
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam int         AW       = ADDR_WIDTH + 2;
   localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t            state, state_nx;
   logic [3:0]        cnt;
   logic [AW-1:0]     addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        f3_q;
   logic              write_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   logic [31:0]       mem [DEPTH];

   logic              accept, legal, commit;
   logic [AW-1:0]     acc_addr;
   logic [31:0]       acc_wdata;
   logic [2:0]        acc_f3;
   logic              acc_write;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [31:0]       load_word, load_data, wdata_rep;
   logic [3:0]        byte_en;

   assign accept = (state == S_IDLE) & req_valid;
   assign legal  = access_ok(req_write, req_funct3, req_addr[1:0]) &&
                   ((req_addr >> AW) == 32'd0);

   // With zero latency the access happens on the accept edge itself, so the
   // access path reads the live request in IDLE and the captured one later.
   assign commit = (LATENCY == 0) ? (accept & legal)
                                  : ((state == S_WAIT) && (cnt == 4'd0));

   assign acc_addr  = (state == S_IDLE) ? req_addr[AW-1:0] : addr_q;
   assign acc_wdata = (state == S_IDLE) ? req_wdata        : wdata_q;
   assign acc_f3    = (state == S_IDLE) ? req_funct3       : f3_q;
   assign acc_write = (state == S_IDLE) ? req_write        : write_q;
   assign word_idx  = acc_addr[AW-1:2];
   assign load_word = mem[word_idx];

   mem_lane_align u_align (
      .funct3     (acc_f3),
      .byte_off   (acc_addr[1:0]),
      .store_data (acc_wdata),
      .load_word  (load_word),
      .byte_en    (byte_en),
      .wdata_rep  (wdata_rep),
      .load_data  (load_data)
   );

   // Storage is never reset. The !rst term keeps a zero-latency accept seen
   // while reset is held from writing anything.
   always_ff @(posedge clk) begin
      if (commit && acc_write && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (req_valid) state_nx = (!legal || LATENCY == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == 4'd0) state_nx = S_RESP;
         S_RESP: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Request capture, wait counter and response registers.
   // rdata_q is only non-zero in the cycle after a load commit, which is
   // always the RESP cycle, so it needs no qualification on the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         write_q <= 1'b0;
         cnt     <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         rdata_q <= (commit && !acc_write) ? load_data : 32'd0;
         case (state)
            S_IDLE: if (accept) begin
               addr_q  <= req_addr[AW-1:0];
               wdata_q <= req_wdata;
               f3_q    <= req_funct3;
               write_q <= req_write;
               err_q   <= ~legal;
               cnt     <= legal ? CNT_LOAD : 4'd0;
            end
            S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            S_RESP: err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance for the
// functional sequence and one LATENCY=0 instance for back-to-back throughput.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam int LAT = 2;
   localparam int AWD = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // LATENCY = 2 instance
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   // LATENCY = 0 instance
   logic        v0 = 1'b0, w0 = 1'b0;
   logic [31:0] a0 = '0, d0 = '0;
   logic [2:0]  f0 = '0;
   logic        ready0, rv0, err0;
   logic [31:0] rd0;

   int n_cmp = 0;
   int n_bad = 0;

   data_mem_responder #(.ADDR_WIDTH(AWD), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.ADDR_WIDTH(AWD), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(v0), .req_ready(ready0), .req_write(w0),
      .req_addr(a0), .req_wdata(d0), .req_funct3(f0),
      .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Issue one request; check latency, err, rdata and the single-cycle pulse.
   task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input logic exp_err, input logic [31:0] exp_rdata);
      int   n;
      logic seen;
      @(negedge clk);
      chk({tag, "/ready"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      @(posedge clk); #1;
      // scramble the payload: it must be ignored after the accept edge
      req_valid = 1'b0; req_write = ~wr; req_addr = 32'h0000_0044;
      req_wdata = 32'h0BAD_0BAD; req_funct3 = F3_B;
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = rsp_valid;
      end
      chk({tag, "/lat"}, 32'(n), exp_err ? 32'd1 : 32'(LAT + 1));
      chk({tag, "/err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, "/rdata"}, rsp_rdata, exp_rdata);
      @(negedge clk);
      chk({tag, "/pulse"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "/rdata0"}, rsp_rdata, 32'd0);
   endtask

   initial begin
      logic seen;
      // reset state
      #12;
      chk("rst/ready", {31'd0, req_ready}, 32'd1);
      chk("rst/valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst/rdata", rsp_rdata, 32'd0);
      chk("rst/err",   {31'd0, rsp_err}, 32'd0);
      chk("rst/cnt",   {28'd0, dut.cnt}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // word store / load and sub-word loads
      do_req("sw10",  1'b1, 32'h10, 32'hDEADBEEF, F3_W,  1'b0, 32'h0);
      do_req("lw10",  1'b0, 32'h10, 32'h0,        F3_W,  1'b0, 32'hDEADBEEF);
      do_req("lb13",  1'b0, 32'h13, 32'h0,        F3_B,  1'b0, 32'hFFFFFFDE);
      do_req("lbu13", 1'b0, 32'h13, 32'h0,        F3_BU, 1'b0, 32'h000000DE);
      do_req("lh12",  1'b0, 32'h12, 32'h0,        F3_H,  1'b0, 32'hFFFFDEAD);
      do_req("lhu10", 1'b0, 32'h10, 32'h0,        F3_HU, 1'b0, 32'h0000BEEF);

      // partial stores
      do_req("sb11",  1'b1, 32'h11, 32'hFFFFFF55, F3_B,  1'b0, 32'h0);
      do_req("lw10b", 1'b0, 32'h10, 32'h0,        F3_W,  1'b0, 32'hDEAD55EF);
      do_req("sh12",  1'b1, 32'h12, 32'hFFFF1234, F3_H,  1'b0, 32'h0);
      do_req("lw10h", 1'b0, 32'h10, 32'h0,        F3_W,  1'b0, 32'h123455EF);

      // rejected requests: no side effect
      do_req("e_lw11",  1'b0, 32'h11,   32'h0,        F3_W,   1'b1, 32'h0);
      do_req("e_sh13",  1'b1, 32'h13,   32'h77777777, F3_H,   1'b1, 32'h0);
      do_req("e_ld011", 1'b0, 32'h10,   32'h0,        3'b011, 1'b1, 32'h0);
      do_req("e_st100", 1'b1, 32'h10,   32'h99999999, 3'b100, 1'b1, 32'h0);
      do_req("e_range", 1'b1, 32'h1000, 32'h88888888, F3_W,   1'b1, 32'h0);
      do_req("lw10e",   1'b0, 32'h10,   32'h0,        F3_W,   1'b0, 32'h123455EF);

      // reset during WAIT drops the pending store
      do_req("sw20", 1'b1, 32'h20, 32'h13572468, F3_W, 1'b0, 32'h0);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
      req_wdata = 32'hAAAAAAAA; req_funct3 = F3_W;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mid/wait", {31'd0, req_ready}, 32'd0);
      @(negedge clk); rst = 1'b1; #1;
      chk("mid/ready", {31'd0, req_ready}, 32'd1);
      seen = rsp_valid;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (3) begin @(negedge clk); seen = seen | rsp_valid; end
      chk("mid/norsp",  {31'd0, seen}, 32'd0);
      chk("mid/ready2", {31'd0, req_ready}, 32'd1);
      do_req("lw20", 1'b0, 32'h20, 32'h0, F3_W, 1'b0, 32'h13572468);

      // zero-latency build with req_valid held high
      @(negedge clk);
      v0 = 1'b1; w0 = 1'b1; a0 = 32'h4; d0 = 32'hCAFEF00D; f0 = F3_W; #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("l0/ready%0d", i), {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("l0/valid%0d", i), {31'd0, rv0},    (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      v0 = 1'b0;
      @(negedge clk);
      v0 = 1'b1; w0 = 1'b0; a0 = 32'h4; f0 = F3_W;
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk);
      chk("l0/lw_valid", {31'd0, rv0}, 32'd1);
      chk("l0/lw_rdata", rd0, 32'hCAFEF00D);
      chk("l0/lw_err",   {31'd0, err0}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
